// File: rtl/lc3_sram_responder.sv
// SRAM-side responder for the LC-3 active-low strobe interface.
// Serves a 2**DEPTH_W word array plus one memory-mapped I/O word (switches on
// read, hex display register on write). Enforces two-cycle read/write timing
// and raises a sticky error flag on strobe sequences the controller should
// never produce.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no operation in progress; a new read or write may start
// RD_ACTIVE | read captured; Data_from_SRAM held while OE stays low
// WR_ARM    | first WE-low edge seen; commit on the next WE-low edge
// WR_HOLD   | write committed; wait for WE to rise, no further commits
module lc3_sram_responder #(
  parameter int          DEPTH_W = 10,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_to_SRAM,
  input  logic [15:0] Switches,
  output logic [15:0] Data_from_SRAM,
  output logic [15:0] HEX_Data,
  output logic        Rd_valid,
  output logic        Wr_done,
  output logic        Proto_err
);

  localparam int DEPTH = 1 << DEPTH_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACTIVE = 2'd1,
    WR_ARM    = 2'd2,
    WR_HOLD   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  rdata_q, rdata_d;
  logic [15:0]  hex_q, hex_d;
  logic         rd_valid_q, rd_valid_d;
  logic         wr_done_q, wr_done_d;
  logic         proto_q, proto_d;
  logic [15:0]  sw_meta_q, sw_sync_q;
  logic [15:0]  mem_q [DEPTH];

  logic               commit;
  logic               io_sel;
  logic [DEPTH_W-1:0] idx;
  logic [15:0]        rd_word;

  // The I/O address wins over array aliasing of the upper address bits.
  assign io_sel  = (ADDR == IO_ADDR);
  assign idx     = ADDR[DEPTH_W-1:0];
  assign rd_word = io_sel ? sw_sync_q : mem_q[idx];

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Next-state and output decode; CE high overrides every state.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    rd_valid_d = rd_valid_q;
    wr_done_d  = 1'b0;
    proto_d    = proto_q;
    commit     = 1'b0;
    if (Mem_CE) begin
      state_d    = IDLE;
      rd_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!Mem_WE) begin
            state_d = WR_ARM;
            if (!Mem_OE) proto_d = 1'b1;
          end else if (!Mem_OE) begin
            rdata_d    = rd_word;
            rd_valid_d = 1'b1;
            state_d    = RD_ACTIVE;
          end
        end
        RD_ACTIVE: begin
          if (!Mem_WE) begin
            proto_d    = 1'b1;
            rd_valid_d = 1'b0;
            state_d    = WR_ARM;
          end else if (Mem_OE) begin
            rd_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        WR_ARM: begin
          if (!Mem_WE) begin
            commit    = 1'b1;
            wr_done_d = 1'b1;
            state_d   = WR_HOLD;
          end else begin
            proto_d = 1'b1;
            state_d = IDLE;
          end
        end
        WR_HOLD: begin
          if (Mem_WE) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Hex display register takes byte-lane writes to the I/O address.
  always_comb begin
    hex_d = hex_q;
    if (commit && io_sel) begin
      if (!Mem_UB) hex_d[15:8] = Data_to_SRAM[15:8];
      if (!Mem_LB) hex_d[7:0]  = Data_to_SRAM[7:0];
    end
  end

  // Control and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      hex_q      <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      hex_q      <= hex_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      proto_q    <= proto_d;
    end
  end

  // Word array with per-byte lane enables; contents survive reset. The
  // commit term is derived from state_q, so an asserted reset blocks writes.
  always_ff @(posedge Clk) begin
    if (commit && !io_sel) begin
      if (!Mem_UB) mem_q[idx][15:8] <= Data_to_SRAM[15:8];
      if (!Mem_LB) mem_q[idx][7:0]  <= Data_to_SRAM[7:0];
    end
  end

  assign Data_from_SRAM = rdata_q;
  assign HEX_Data       = hex_q;
  assign Rd_valid       = rd_valid_q;
  assign Wr_done        = wr_done_q;
  assign Proto_err      = proto_q;

endmodule

// File: tb/tb_lc3_sram_responder.sv
module tb_lc3_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [15:0] ADDR, Data_to_SRAM, Switches;
  logic [15:0] Data_from_SRAM, HEX_Data;
  logic        Rd_valid, Wr_done, Proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  lc3_sram_responder #(.DEPTH_W(10), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Switches(Switches),
    .Data_from_SRAM(Data_from_SRAM), .HEX_Data(HEX_Data),
    .Rd_valid(Rd_valid), .Wr_done(Wr_done), .Proto_err(Proto_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ce, ub, lb, oe, we;
    logic [15:0] addr, wdata;
    logic        rv, wd, pe;
    logic [15:0] data, hex;
  } vec_t;

  vec_t vq[$];

  function automatic void row(input logic ce, ub, lb, oe, we,
                              input logic [15:0] addr, wdata,
                              input logic rv, wd, pe,
                              input logic [15:0] data, hex);
    vec_t v;
    v.ce = ce; v.ub = ub; v.lb = lb; v.oe = oe; v.we = we;
    v.addr = addr; v.wdata = wdata;
    v.rv = rv; v.wd = wd; v.pe = pe; v.data = data; v.hex = hex;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic rv, wd, pe,
                         input logic [15:0] data, hex);
    chk({tag, ".Rd_valid"},       {15'd0, Rd_valid},  {15'd0, rv});
    chk({tag, ".Wr_done"},        {15'd0, Wr_done},   {15'd0, wd});
    chk({tag, ".Proto_err"},      {15'd0, Proto_err}, {15'd0, pe});
    chk({tag, ".Data_from_SRAM"}, Data_from_SRAM,     data);
    chk({tag, ".HEX_Data"},       HEX_Data,           hex);
  endtask

  task automatic drive(input logic ce, ub, lb, oe, we, input logic [15:0] addr, wdata);
    Mem_CE = ce; Mem_UB = ub; Mem_LB = lb; Mem_OE = oe; Mem_WE = we;
    ADDR = addr; Data_to_SRAM = wdata;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // ce ub lb oe we  addr      wdata     rv wd pe  data      hex
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'h0000, 16'h0000); // 1 idle
    row(0,0,0,1,0, 16'h0003, 16'h1234, 0,0,0, 16'h0000, 16'h0000); // 2 arm
    row(0,0,0,1,0, 16'h0003, 16'h1234, 0,1,0, 16'h0000, 16'h0000); // 3 commit
    row(1,1,1,1,1, 16'h0003, 16'h0000, 0,0,0, 16'h0000, 16'h0000); // 4
    row(0,1,1,0,1, 16'h0003, 16'h0000, 1,0,0, 16'h1234, 16'h0000); // 5 read cap
    row(0,1,1,0,1, 16'h0003, 16'h0000, 1,0,0, 16'h1234, 16'h0000); // 6 2nd cycle
    row(0,1,1,1,1, 16'h0003, 16'h0000, 0,0,0, 16'h1234, 16'h0000); // 7 OE up
    row(0,0,0,1,0, 16'h0010, 16'hBEEF, 0,0,0, 16'h1234, 16'h0000); // 8
    row(0,0,0,1,0, 16'h0010, 16'hBEEF, 0,1,0, 16'h1234, 16'h0000); // 9
    row(0,1,1,1,1, 16'h0010, 16'h0000, 0,0,0, 16'h1234, 16'h0000); // 10
    row(0,1,1,0,1, 16'h0010, 16'h0000, 1,0,0, 16'hBEEF, 16'h0000); // 11
    row(0,1,1,0,1, 16'h0003, 16'h0000, 1,0,0, 16'hBEEF, 16'h0000); // 12 no re-read
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hBEEF, 16'h0000); // 13
    row(0,0,0,1,0, 16'h0005, 16'hAAAA, 0,0,0, 16'hBEEF, 16'h0000); // 14
    row(0,0,0,1,0, 16'h0005, 16'hAAAA, 0,1,0, 16'hBEEF, 16'h0000); // 15
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hBEEF, 16'h0000); // 16
    row(0,1,0,1,0, 16'h0005, 16'h1234, 0,0,0, 16'hBEEF, 16'h0000); // 17 LB only
    row(0,1,0,1,0, 16'h0005, 16'h1234, 0,1,0, 16'hBEEF, 16'h0000); // 18
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hBEEF, 16'h0000); // 19
    row(0,1,1,0,1, 16'h0005, 16'h0000, 1,0,0, 16'hAA34, 16'h0000); // 20
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hAA34, 16'h0000); // 21
    row(0,0,1,1,0, 16'h0005, 16'hFF00, 0,0,0, 16'hAA34, 16'h0000); // 22 UB only
    row(0,0,1,1,0, 16'h0005, 16'hFF00, 0,1,0, 16'hAA34, 16'h0000); // 23
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hAA34, 16'h0000); // 24
    row(0,1,1,0,1, 16'h0005, 16'h0000, 1,0,0, 16'hFF34, 16'h0000); // 25
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hFF34, 16'h0000); // 26
    row(0,1,1,1,0, 16'h0005, 16'h0000, 0,0,0, 16'hFF34, 16'h0000); // 27 no lanes
    row(0,1,1,1,0, 16'h0005, 16'h0000, 0,1,0, 16'hFF34, 16'h0000); // 28
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hFF34, 16'h0000); // 29
    row(0,1,1,0,1, 16'h0005, 16'h0000, 1,0,0, 16'hFF34, 16'h0000); // 30
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hFF34, 16'h0000); // 31
    row(0,0,0,1,0, 16'h03FF, 16'h7777, 0,0,0, 16'hFF34, 16'h0000); // 32
    row(0,0,0,1,0, 16'h03FF, 16'h7777, 0,1,0, 16'hFF34, 16'h0000); // 33
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'hFF34, 16'h0000); // 34
    row(0,1,1,0,1, 16'hFFFF, 16'h0000, 1,0,0, 16'h00C3, 16'h0000); // 35 switches
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'h00C3, 16'h0000); // 36
    row(0,0,0,1,0, 16'hFFFF, 16'h5A5A, 0,0,0, 16'h00C3, 16'h0000); // 37
    row(0,0,0,1,0, 16'hFFFF, 16'h5A5A, 0,1,0, 16'h00C3, 16'h5A5A); // 38 hex
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'h00C3, 16'h5A5A); // 39
    row(0,1,1,0,1, 16'h03FF, 16'h0000, 1,0,0, 16'h7777, 16'h5A5A); // 40 untouched
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'h7777, 16'h5A5A); // 41
    row(0,0,1,1,0, 16'hFFFF, 16'h1200, 0,0,0, 16'h7777, 16'h5A5A); // 42
    row(0,0,1,1,0, 16'hFFFF, 16'h1200, 0,1,0, 16'h7777, 16'h125A); // 43
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'h7777, 16'h125A); // 44
    row(0,1,1,0,1, 16'h07FF, 16'h0000, 1,0,0, 16'h7777, 16'h125A); // 45 alias
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,0, 16'h7777, 16'h125A); // 46
    row(0,0,0,1,0, 16'h0003, 16'hDEAD, 0,0,0, 16'h7777, 16'h125A); // 47 arm
    row(0,1,1,1,1, 16'h0003, 16'hDEAD, 0,0,1, 16'h7777, 16'h125A); // 48 short WE
    row(0,1,1,0,1, 16'h0003, 16'h0000, 1,0,1, 16'h1234, 16'h125A); // 49
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,1, 16'h1234, 16'h125A); // 50
    row(0,0,0,0,0, 16'h0003, 16'h4321, 0,0,1, 16'h1234, 16'h125A); // 51 OE+WE
    row(0,0,0,0,0, 16'h0003, 16'h4321, 0,1,1, 16'h1234, 16'h125A); // 52
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,1, 16'h1234, 16'h125A); // 53
    row(0,1,1,0,1, 16'h0003, 16'h0000, 1,0,1, 16'h4321, 16'h125A); // 54
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,1, 16'h4321, 16'h125A); // 55
    row(0,0,0,1,0, 16'h0003, 16'h1111, 0,0,1, 16'h4321, 16'h125A); // 56 arm
    row(1,0,0,1,0, 16'h0003, 16'h1111, 0,0,1, 16'h4321, 16'h125A); // 57 CE abort
    row(0,1,1,0,1, 16'h0003, 16'h0000, 1,0,1, 16'h4321, 16'h125A); // 58
    row(1,1,1,1,1, 16'h0000, 16'h0000, 0,0,1, 16'h4321, 16'h125A); // 59

    Switches = 16'h00C3;
    drive(1, 1, 1, 1, 1, 16'h0000, 16'h0000);
    Reset = 1'b0;
    #12;
    chk_all("reset", 0, 0, 0, 16'h0000, 16'h0000);
    @(negedge Clk);
    Reset = 1'b1;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ce, vq[i].ub, vq[i].lb, vq[i].oe, vq[i].we, vq[i].addr, vq[i].wdata);
      step();
      chk_all($sformatf("vec%0d", i + 1), vq[i].rv, vq[i].wd, vq[i].pe, vq[i].data, vq[i].hex);
    end

    // Reset during the second WE-low cycle: nothing commits, outputs clear.
    drive(0, 0, 0, 1, 0, 16'h0003, 16'h2222);
    step();
    #2 Reset = 1'b0;
    #1;
    chk_all("rst_midwr", 0, 0, 0, 16'h0000, 16'h0000);
    step();
    chk_all("rst_hold", 0, 0, 0, 16'h0000, 16'h0000);
    drive(1, 1, 1, 1, 1, 16'h0000, 16'h0000);
    Reset = 1'b1;
    step();
    drive(0, 1, 1, 0, 1, 16'h0003, 16'h0000);
    step();
    chk_all("rst_readback", 1, 0, 0, 16'h4321, 16'h0000);

    // Reset during a read clears the captured data.
    #2 Reset = 1'b0;
    #1;
    chk_all("rst_midrd", 0, 0, 0, 16'h0000, 16'h0000);
    drive(1, 1, 1, 1, 1, 16'h0000, 16'h0000);
    step();
    Reset = 1'b1;
    step();
    chk_all("post_rst", 0, 0, 0, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
